// File: rtl/shift_seq_ctrl.sv
// Two-requester shift sequencer sharing one left barrel shifter (right shifts via bit reversal).
// Optional macro SHIFT_SEQ_ROTATE_EN enables op 11 as ROL (second ROT2 pass); otherwise op 11 is SHL.
module shift_seq_ctrl #(
  parameter  int WIDTH = 32,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [AMT_W-1:0] req1_amt,
  input  logic [WIDTH-1:0] req1_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cf,
  output logic [1:0]       o_dbg_state
);

  // Handshake: a request transfers in the IDLE cycle where reqN_valid & reqN_ready;
  // the response transfers on the edge where rsp_valid & rsp_ready, and rsp_* hold until then.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
`ifdef SHIFT_SEQ_ROTATE_EN
    S_ROT2 = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0]       OP_SHR = 2'b01;
  localparam logic [1:0]       OP_SAR = 2'b10;
`ifdef SHIFT_SEQ_ROTATE_EN
  localparam logic [1:0]       OP_ROL = 2'b11;
`endif
  localparam logic [WIDTH-1:0] ONES   = '1;

  state_t           r_state;
  logic             r_rr_ptr;
  logic [1:0]       r_op;
  logic [AMT_W-1:0] r_amt;
  logic [WIDTH-1:0] r_data;
  logic             r_id;
  logic [WIDTH-1:0] r_result;
  logic             r_cf;
  logic             r_rsp_valid;

  logic             w_any;
  logic             w_gnt_id;
  logic             w_idle_gnt;
  logic [AMT_W-1:0] w_neg_amt;
  logic             w_cf_rev;
  logic             w_cf;
  logic             w_rev;
  logic             w_fill;
  logic [AMT_W-1:0] w_sh_amt;
  logic [WIDTH-1:0] w_sh_in;
  logic [WIDTH-1:0] w_sh_raw;
  logic [WIDTH-1:0] w_sh_out;

  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  assign w_any      = req0_valid | req1_valid;
  assign w_gnt_id   = (req0_valid & req1_valid) ? r_rr_ptr : req1_valid;
  assign w_idle_gnt = (r_state == S_IDLE) & ~rst & w_any;
  assign req0_ready = w_idle_gnt & ~w_gnt_id;
  assign req1_ready = w_idle_gnt & w_gnt_id;

  // WIDTH-amt wraps cleanly in AMT_W bits because WIDTH is a power of two.
  assign w_neg_amt = ~r_amt + 1'b1;
  assign w_cf_rev  = (r_op == OP_SHR) || (r_op == OP_SAR);

  always_comb begin
    w_cf = 1'b0;
    if (r_amt != '0) begin
      if (w_cf_rev) w_cf = r_data[r_amt - 1'b1];
      else          w_cf = r_data[w_neg_amt];
    end
  end

  always_comb begin
    w_rev    = w_cf_rev;
    w_sh_amt = r_amt;
`ifdef SHIFT_SEQ_ROTATE_EN
    if (r_state == S_ROT2) begin
      w_rev    = 1'b1;
      w_sh_amt = w_neg_amt;
    end
`endif
    w_fill   = (r_op == OP_SAR) && r_data[WIDTH-1];
    w_sh_in  = w_rev ? bitrev(r_data) : r_data;
    w_sh_raw = (w_sh_in << w_sh_amt) | (w_fill ? ~(ONES << w_sh_amt) : '0);
    w_sh_out = w_rev ? bitrev(w_sh_raw) : w_sh_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= 1'b0;
      r_op        <= '0;
      r_amt       <= '0;
      r_data      <= '0;
      r_id        <= 1'b0;
      r_result    <= '0;
      r_cf        <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_op     <= w_gnt_id ? req1_op   : req0_op;
            r_amt    <= w_gnt_id ? req1_amt  : req0_amt;
            r_data   <= w_gnt_id ? req1_data : req0_data;
            r_id     <= w_gnt_id;
            r_rr_ptr <= ~w_gnt_id;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_result <= w_sh_out;
          r_cf     <= w_cf;
`ifdef SHIFT_SEQ_ROTATE_EN
          if ((r_op == OP_ROL) && (r_amt != '0)) begin
            r_state <= S_ROT2;
          end else begin
            r_state     <= S_DONE;
            r_rsp_valid <= 1'b1;
          end
`else
          r_state     <= S_DONE;
          r_rsp_valid <= 1'b1;
`endif
        end
`ifdef SHIFT_SEQ_ROTATE_EN
        S_ROT2: begin
          // Bits wrapped past the MSB come back in from the right-shift pass.
          r_result    <= r_result | w_sh_out;
          r_state     <= S_DONE;
          r_rsp_valid <= 1'b1;
        end
`endif
        S_DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_id;
  assign rsp_data    = r_result;
  assign rsp_cf      = r_cf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl (WIDTH=32): vector table plus backpressure, reset and arbitration sequences.
module tb_shift_seq_ctrl;
  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]    req0_op, req1_op;
  logic [AW-1:0] req0_amt, req1_amt;
  logic [W-1:0]  req0_data, req1_data;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_cf;
  logic [W-1:0]  rsp_data;
  logic [1:0]    o_dbg_state;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_amt(req0_amt), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_amt(req1_amt), .req1_data(req1_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_cf(rsp_cf), .o_dbg_state(o_dbg_state)
  );

  typedef struct {
    logic          id;
    logic [1:0]    op;
    logic [AW-1:0] amt;
    logic [W-1:0]  data;
    logic [W-1:0]  exp_data;
    logic          exp_cf;
    int            exp_lat;
  } vec_t;

  vec_t        vecs[13];
  logic [W:0]  exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic scramble_idle_inputs();
    req0_op = 2'($urandom_range(0, 3)); req0_amt = AW'($urandom_range(0, 31)); req0_data = $urandom;
    req1_op = 2'($urandom_range(0, 3)); req1_amt = AW'($urandom_range(0, 31)); req1_data = $urandom;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [W:0] e;
    int lat;
    scramble_idle_inputs();
    if (v.id) begin
      req1_valid = 1'b1; req1_op = v.op; req1_amt = v.amt; req1_data = v.data; req0_valid = 1'b0;
    end else begin
      req0_valid = 1'b1; req0_op = v.op; req0_amt = v.amt; req0_data = v.data; req1_valid = 1'b0;
    end
    #1;
    check($sformatf("v%0d_ready_own", idx), v.id ? req1_ready : req0_ready, 1);
    check($sformatf("v%0d_ready_other", idx), v.id ? req0_ready : req1_ready, 0);
    exp_q.push_back({v.id, v.exp_data});
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    scramble_idle_inputs();
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    e = exp_q.pop_front();
    check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d_rsp_valid", idx), rsp_valid, 1);
    check($sformatf("v%0d_rsp_data", idx), rsp_data, e[W-1:0]);
    check($sformatf("v%0d_rsp_id", idx), rsp_id, e[W]);
    check($sformatf("v%0d_rsp_cf", idx), rsp_cf, v.exp_cf);
    @(negedge clk);
    check($sformatf("v%0d_consumed", idx), rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0] e;
    int lat, grants, resps, last_g, cyc;
    logic g;

    vecs[0]  = '{1'b0, 2'b00, 5'd4,  32'h8000_000F, 32'h0000_00F0, 1'b0, 2};
    vecs[1]  = '{1'b1, 2'b10, 5'd8,  32'h8000_1200, 32'hFF80_0012, 1'b0, 2};
    vecs[2]  = '{1'b1, 2'b01, 5'd8,  32'h8000_1200, 32'h0080_0012, 1'b0, 2};
`ifdef SHIFT_SEQ_ROTATE_EN
    vecs[3]  = '{1'b0, 2'b11, 5'd4,  32'h1234_5678, 32'h2345_6781, 1'b1, 3};
    vecs[10] = '{1'b0, 2'b11, 5'd31, 32'h0000_0003, 32'h8000_0001, 1'b1, 3};
`else
    vecs[3]  = '{1'b0, 2'b11, 5'd4,  32'h1234_5678, 32'h2345_6780, 1'b1, 2};
    vecs[10] = '{1'b0, 2'b11, 5'd31, 32'h0000_0003, 32'h8000_0000, 1'b1, 2};
`endif
    vecs[4]  = '{1'b0, 2'b00, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 2};
    vecs[5]  = '{1'b1, 2'b01, 5'd1,  32'h0000_0003, 32'h0000_0001, 1'b1, 2};
    vecs[6]  = '{1'b0, 2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 2};
    vecs[7]  = '{1'b1, 2'b10, 5'd31, 32'h4000_0000, 32'h0000_0000, 1'b1, 2};
    vecs[8]  = '{1'b0, 2'b00, 5'd31, 32'h0000_0003, 32'h8000_0000, 1'b1, 2};
    vecs[9]  = '{1'b1, 2'b11, 5'd0,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 2};
    vecs[11] = '{1'b1, 2'b01, 5'd16, 32'hABCD_1234, 32'h0000_ABCD, 1'b0, 2};
    vecs[12] = '{1'b0, 2'b10, 5'd4,  32'h7000_000F, 32'h0700_0000, 1'b1, 2};

    // Reset with both requesters asserting: no grant may be offered.
    rst = 1'b1; rsp_ready = 1'b1;
    scramble_idle_inputs();
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check("post_rst_state", o_dbg_state, 0);
    check("post_rst_rsp_valid", rsp_valid, 0);
    check("post_rst_rsp_data", rsp_data, 0);
    check("post_rst_rsp_id", rsp_id, 0);
    check("post_rst_rsp_cf", rsp_cf, 0);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Backpressure: response held stable for 5 cycles, no grants offered.
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_op = 2'b00; req1_amt = 5'd4; req1_data = 32'h1000_0F01;
    #1;
    check("bp_grant", req1_ready, 1);
    @(negedge clk);
    req1_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", lat, 2);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp%0d_valid", k), rsp_valid, 1);
      check($sformatf("bp%0d_data", k), rsp_data, 32'h0000_F010);
      check($sformatf("bp%0d_cf", k), rsp_cf, 1);
      check($sformatf("bp%0d_id", k), rsp_id, 1);
      check($sformatf("bp%0d_readys", k), {req0_ready, req1_ready}, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", rsp_valid, 0);
    check("bp_release_state", o_dbg_state, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    // Reset during EXEC: op abandoned, outputs cleared, no response afterwards.
    req0_valid = 1'b1; req0_op = 2'b00; req0_amt = 5'd1; req0_data = 32'hFFFF_FFFF;
    #1;
    check("mid_grant", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    check("mid_in_exec", o_dbg_state, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_state", o_dbg_state, 0);
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_data", rsp_data, 0);
    check("mid_rst_cf", rsp_cf, 0);
    check("mid_rst_id", rsp_id, 0);
    check("mid_rst_readys", {req0_ready, req1_ready}, 0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("mid_no_rsp%0d", k), rsp_valid, 0);
    end

    // Both valid every cycle: grants alternate 0,1,0,1 from rr_ptr=0, one per 3 cycles.
    exp_q.delete();
    req0_valid = 1'b1; req0_op = 2'b00; req0_amt = 5'd1; req0_data = 32'h0000_0001;
    req1_valid = 1'b1; req1_op = 2'b01; req1_amt = 5'd1; req1_data = 32'h0000_0004;
    grants = 0; resps = 0; last_g = -1; cyc = 0;
    while ((grants < 4 || resps < 4) && cyc < 60) begin
      if (grants >= 4) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      #1;
      if (req0_ready || req1_ready) begin
        g = req1_ready;
        check($sformatf("alt_grant%0d", grants), g, (grants % 2 == 1));
        check($sformatf("alt_single%0d", grants), req0_ready & req1_ready, 0);
        if (last_g >= 0) check($sformatf("alt_spacing%0d", grants), cyc - last_g, 3);
        last_g = cyc;
        exp_q.push_back({g, 32'h0000_0002});
        grants++;
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("alt_unexpected_rsp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("alt_rsp_id%0d", resps), rsp_id, e[W]);
          check($sformatf("alt_rsp_data%0d", resps), rsp_data, e[W-1:0]);
        end
        resps++;
      end
      @(negedge clk);
      cyc++;
    end
    check("alt_completed", (grants == 4) && (resps == 4), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
